// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch queue.
// Holds the fetch FSM state encoding, the queued {pc, instr} entry and a PC alignment helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [63:0] INSTR_BYTES = 64'd4;

    function automatic logic [63:0] align_pc(input logic [63:0] pc);
        return {pc[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO of fetched {pc, instr} entries with flush.
// Ports: i_clk, i_rst_n (async low), i_flush, i_push/i_entry, i_pop, o_head, o_count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  fetch_entry_t i_entry,
    input  logic         i_pop,
    output fetch_entry_t o_head,
    output logic [AW:0]  o_count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;

    logic w_pop;
    logic w_push;

    // Flush wins over both push and pop.
    assign w_pop  = i_pop && !i_flush && (r_count != '0);
    assign w_push = i_push && !i_flush && ((r_count != FULL_CNT) || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= i_entry;
                    r_wr_ptr        <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues one word fetch at a time and buffers responses for IF/ID.
// Ports: clk, reset (async low), req_*/resp_* memory side, out_* IF/ID side, redirect_* flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        req_valid,
    output logic [63:0] req_addr,
    input  logic        req_ready,
    input  logic        resp_valid,
    input  logic [31:0] resp_data,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [63:0]  r_fetch_pc;
    logic [63:0]  w_fetch_pc_nxt;
    logic [63:0]  r_pend_pc;
    logic [63:0]  w_pend_pc_nxt;

    logic         w_req_fire;
    logic         w_push;
    logic         w_pop;
    logic [AW:0]  w_count;
    fetch_entry_t w_head;
    fetch_entry_t w_push_entry;

    // Only one request is ever outstanding and it is issued with a free
    // slot, so the response always has room when it arrives.
    assign req_valid  = reset && (r_state == FETCH)
                        && (w_count != FULL_CNT) && !redirect_valid;
    assign req_addr   = r_fetch_pc;
    assign w_req_fire = req_valid && req_ready;

    assign w_push       = (r_state == WAIT) && resp_valid && !redirect_valid;
    assign w_pop        = out_valid && out_ready && !redirect_valid;
    assign w_push_entry = '{pc: r_pend_pc, instr: resp_data};

    assign out_valid = (w_count != '0);
    assign out_pc    = w_head.pc;
    assign out_instr = w_head.instr;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_pend_pc_nxt  = r_pend_pc;

        unique case (r_state)
            FETCH: begin
                if (w_req_fire) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                // A response arriving with a redirect has nothing left to
                // wait for, so it is discarded and fetching resumes.
                if (resp_valid) begin
                    w_state_nxt = FETCH;
                end else if (redirect_valid) begin
                    w_state_nxt = DROP;
                end
            end
            DROP: begin
                if (resp_valid) begin
                    w_state_nxt = FETCH;
                end
            end
            default: begin
                w_state_nxt = FETCH;
            end
        endcase

        if (redirect_valid) begin
            w_fetch_pc_nxt = align_pc(redirect_pc);
        end else if (w_req_fire) begin
            w_fetch_pc_nxt = r_fetch_pc + INSTR_BYTES;
        end

        if (w_req_fire) begin
            w_pend_pc_nxt = r_fetch_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= FETCH;
            r_fetch_pc <= RESET_PC;
            r_pend_pc  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_pend_pc  <= w_pend_pc_nxt;
        end
    end

endmodule
